// File: rtl/barrier_sched_pkg.sv
// Shared types for the per-core barrier scheduler: global-barrier FSM encoding and cluster request record.
package barrier_sched_pkg;

    typedef logic [1:0] gbar_state_t;
    localparam gbar_state_t GBAR_IDLE = 2'd0;
    localparam gbar_state_t GBAR_REQ  = 2'd1;
    localparam gbar_state_t GBAR_WAIT = 2'd2;

    localparam int GBAR_ID_W = 8;

    typedef struct packed {
        logic [GBAR_ID_W-1:0] id;
        logic [31:0]          core_id;
    } gbar_req_t;

endpackage

// File: rtl/barrier_sched_prio_enc.sv
// Lowest-index-wins priority encoder used to pick the next pending global barrier.
module barrier_sched_prio_enc #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/barrier_sched.sv
// Per-core warp barrier scheduler: tracks arrivals, stalls warps, releases on fill.
// Define GBAR_FWD_EN to forward global barriers to the cluster over the gbar_* handshake.
module barrier_sched
    import barrier_sched_pkg::*;
#(
    parameter  int NUM_WARPS    = 4,
    parameter  int NUM_BARRIERS = 4,
    parameter  int CORE_ID      = 0,
    localparam int NW_W         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNT_W        = NW_W + 1,
    localparam int NB_W         = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_valid,
    input  logic [NW_W-1:0]      bar_wid,
    input  logic [NB_W-1:0]      bar_id,
    input  logic [NW_W-1:0]      bar_size_m1,
    input  logic                 bar_is_noop,
    input  logic                 bar_is_global,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic                 gbar_req_valid,
    output logic [NB_W-1:0]      gbar_req_id,
    output logic [31:0]          gbar_req_core_id,
    input  logic                 gbar_req_ready,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_W-1:0]      gbar_rsp_id
);

    logic [CNT_W-1:0]     cnt_q   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];

    logic [NUM_WARPS-1:0] wid_onehot;
    logic [NUM_WARPS-1:0] loc_rel_mask;
    logic                 dup, arrive, is_final, loc_final;

    assign wid_onehot   = NUM_WARPS'(1) << bar_wid;
    assign dup          = |(wmask_q[bar_id] & wid_onehot);
    assign arrive       = bar_valid && !bar_is_noop && !dup;
    assign is_final     = (cnt_q[bar_id] == CNT_W'(bar_size_m1));
    assign loc_rel_mask = wmask_q[bar_id] | wid_onehot;

    always_comb begin
        stall_mask = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) stall_mask |= wmask_q[b];
    end

`ifdef GBAR_FWD_EN
    gbar_state_t          state_q;
    gbar_req_t            req_q;
    logic [NB_W-1:0]      cur_id;
    logic [NUM_BARRIERS-1:0] pend_q, enc_req;
    logic [NB_W-1:0]      enc_idx;
    logic                 enc_valid, glb_final, glb_rel;
    logic                 hold_valid_q;
    logic [NUM_WARPS-1:0] hold_wmask_q;

    assign cur_id    = req_q.id[NB_W-1:0];
    assign glb_final = arrive && is_final && bar_is_global;
    assign loc_final = arrive && is_final && !bar_is_global;
    assign glb_rel   = (state_q == GBAR_WAIT) && gbar_rsp_valid
                       && (req_q.id == GBAR_ID_W'(gbar_rsp_id));
    // A barrier filling this cycle is eligible immediately, saving a cycle of request latency.
    assign enc_req   = pend_q | (glb_final ? (NUM_BARRIERS'(1) << bar_id) : '0);

    barrier_sched_prio_enc #(.N(NUM_BARRIERS)) u_prio_enc (
        .req   (enc_req),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign gbar_req_valid   = (state_q == GBAR_REQ);
    assign gbar_req_id      = cur_id;
    assign gbar_req_core_id = req_q.core_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= GBAR_IDLE;
            req_q        <= '{id: '0, core_id: 32'(CORE_ID)};
            pend_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_wmask_q <= '0;
        end else begin
            case (state_q)
                GBAR_IDLE: if (enc_valid) begin
                    state_q  <= GBAR_REQ;
                    req_q.id <= GBAR_ID_W'(enc_idx);
                end
                GBAR_REQ:  if (gbar_req_ready) state_q <= GBAR_WAIT;
                GBAR_WAIT: if (glb_rel) state_q <= GBAR_IDLE;
                default:   state_q <= GBAR_IDLE;
            endcase
            if (glb_rel)   pend_q[cur_id] <= 1'b0;
            if (glb_final) pend_q[bar_id] <= 1'b1;
            // Only one global release can collide per FSM round, so one entry always drains in time.
            hold_valid_q <= loc_final && (glb_rel || hold_valid_q);
            hold_wmask_q <= loc_rel_mask;
        end
    end

    a_rsp_match: assert property (@(posedge clk) disable iff (!reset)
        (state_q == GBAR_WAIT && gbar_rsp_valid) |-> (req_q.id == GBAR_ID_W'(gbar_rsp_id)));
`else
    logic unused_gbar;

    assign unused_gbar      = &{1'b0, bar_is_global, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id};
    assign loc_final        = arrive && is_final;
    assign gbar_req_valid   = 1'b0;
    assign gbar_req_id      = '0;
    assign gbar_req_core_id = 32'(CORE_ID);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the per-barrier arrays must be reset; a stale count or mask would corrupt the next barrier.
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                cnt_q[b]   <= '0;
                wmask_q[b] <= '0;
            end
            release_valid <= 1'b0;
            release_wmask <= '0;
        end else begin
`ifdef GBAR_FWD_EN
            if (glb_rel) begin
                cnt_q[cur_id]   <= '0;
                wmask_q[cur_id] <= '0;
            end
`endif
            if (loc_final) begin
                cnt_q[bar_id]   <= '0;
                wmask_q[bar_id] <= '0;
            end else if (arrive) begin
                wmask_q[bar_id] <= loc_rel_mask;
                if (!is_final) cnt_q[bar_id] <= cnt_q[bar_id] + CNT_W'(1);
            end
`ifdef GBAR_FWD_EN
            if (glb_rel) begin
                release_valid <= 1'b1;
                release_wmask <= wmask_q[cur_id];
            end else if (hold_valid_q) begin
                release_valid <= 1'b1;
                release_wmask <= hold_wmask_q;
            end else begin
                release_valid <= loc_final;
                release_wmask <= loc_final ? loc_rel_mask : '0;
            end
`else
            release_valid <= loc_final;
            release_wmask <= loc_final ? loc_rel_mask : '0;
`endif
        end
    end

    a_no_dup: assert property (@(posedge clk) disable iff (!reset)
        !(bar_valid && !bar_is_noop && dup));

endmodule

// File: tb/tb_barrier_sched.sv
// Directed, table-driven bench for barrier_sched; global-forwarding sequences compile in with GBAR_FWD_EN.
module tb_barrier_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       bar_valid;
    logic [1:0] bar_wid, bar_id, bar_size_m1;
    logic       bar_is_noop, bar_is_global;
    logic [3:0] stall_mask, release_wmask;
    logic       release_valid, gbar_req_valid;
    logic [1:0] gbar_req_id;
    logic [31:0] gbar_req_core_id;
    logic       gbar_req_ready, gbar_rsp_valid;
    logic [1:0] gbar_rsp_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    barrier_sched #(.NUM_WARPS(4), .NUM_BARRIERS(4), .CORE_ID(0)) dut (
        .clk              (clk),
        .reset            (reset),
        .bar_valid        (bar_valid),
        .bar_wid          (bar_wid),
        .bar_id           (bar_id),
        .bar_size_m1      (bar_size_m1),
        .bar_is_noop      (bar_is_noop),
        .bar_is_global    (bar_is_global),
        .stall_mask       (stall_mask),
        .release_valid    (release_valid),
        .release_wmask    (release_wmask),
        .gbar_req_valid   (gbar_req_valid),
        .gbar_req_id      (gbar_req_id),
        .gbar_req_core_id (gbar_req_core_id),
        .gbar_req_ready   (gbar_req_ready),
        .gbar_rsp_valid   (gbar_rsp_valid),
        .gbar_rsp_id      (gbar_rsp_id)
    );

    typedef struct {
        logic       v;
        logic [1:0] wid, id, sm1;
        logic       noop, glb;
        logic [3:0] stall;
        logic       rv;
        logic [3:0] rm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] wid, input logic [1:0] id,
                       input logic [1:0] sm1, input logic noop, input logic glb,
                       input logic [3:0] stall, input logic rv, input logic [3:0] rm);
        vec_t e;
        e.v = v; e.wid = wid; e.id = id; e.sm1 = sm1; e.noop = noop; e.glb = glb;
        e.stall = stall; e.rv = rv; e.rm = rm;
        vecs.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [1:0] wid, input logic [1:0] id,
                         input logic [1:0] sm1, input logic glb);
        bar_valid = v; bar_wid = wid; bar_id = id; bar_size_m1 = sm1;
        bar_is_noop = 1'b0; bar_is_global = glb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        gbar_req_ready = 1'b0; gbar_rsp_valid = 1'b0; gbar_rsp_id = 2'd0;
        idle();
        step(); step();
        check("reset_stall", 32'(stall_mask), 32'h0);
        check("reset_rel_valid", 32'(release_valid), 32'h0);
        check("reset_rel_mask", 32'(release_wmask), 32'h0);
        check("reset_greq_valid", 32'(gbar_req_valid), 32'h0);
        check("reset_greq_id", 32'(gbar_req_id), 32'h0);
        check("core_id", gbar_req_core_id, 32'h0);
        reset = 1'b1;
        step();

        //  v   wid   id    sm1  noop glb  stall  rv  rm
        add(1, 2'd0, 2'd0, 2'd2, 0, 0, 4'b0001, 0, 4'b0000);
        add(1, 2'd1, 2'd0, 2'd2, 0, 0, 4'b0011, 0, 4'b0000);
        add(1, 2'd2, 2'd0, 2'd2, 0, 0, 4'b0000, 1, 4'b0111);
        add(1, 2'd3, 2'd0, 2'd2, 1, 0, 4'b0000, 0, 4'b0000);
        add(0, 2'd0, 2'd0, 2'd0, 0, 0, 4'b0000, 0, 4'b0000);
        add(1, 2'd0, 2'd1, 2'd1, 0, 0, 4'b0001, 0, 4'b0000);
        add(1, 2'd1, 2'd2, 2'd1, 0, 0, 4'b0011, 0, 4'b0000);
        add(1, 2'd2, 2'd2, 2'd1, 0, 0, 4'b0001, 1, 4'b0110);
        add(1, 2'd3, 2'd1, 2'd1, 0, 0, 4'b0000, 1, 4'b1001);
        add(1, 2'd3, 2'd3, 2'd0, 0, 0, 4'b0000, 1, 4'b1000);
        add(1, 2'd3, 2'd1, 2'd3, 0, 0, 4'b1000, 0, 4'b0000);
        add(1, 2'd2, 2'd1, 2'd3, 0, 0, 4'b1100, 0, 4'b0000);
        add(1, 2'd1, 2'd1, 2'd3, 0, 0, 4'b1110, 0, 4'b0000);
        add(1, 2'd0, 2'd1, 2'd3, 0, 0, 4'b0000, 1, 4'b1111);
        add(0, 2'd0, 2'd0, 2'd0, 0, 0, 4'b0000, 0, 4'b0000);
`ifndef GBAR_FWD_EN
        add(1, 2'd0, 2'd3, 2'd1, 0, 1, 4'b0001, 0, 4'b0000);
        add(1, 2'd1, 2'd3, 2'd1, 0, 1, 4'b0000, 1, 4'b0011);
        add(0, 2'd0, 2'd0, 2'd0, 0, 0, 4'b0000, 0, 4'b0000);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].wid, vecs[i].id, vecs[i].sm1, vecs[i].glb);
            bar_is_noop = vecs[i].noop;
            step();
            check($sformatf("vec%0d_stall", i), 32'(stall_mask), 32'(vecs[i].stall));
            check($sformatf("vec%0d_rel_valid", i), 32'(release_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_rel_mask", i), 32'(release_wmask), 32'(vecs[i].rm));
            check($sformatf("vec%0d_greq", i), 32'(gbar_req_valid), 32'h0);
        end

`ifdef GBAR_FWD_EN
        // Global barrier 3: request held until ready, release after response.
        drive(1'b1, 2'd0, 2'd3, 2'd1, 1'b1); step();
        check("g_stall0", 32'(stall_mask), 32'b0001);
        drive(1'b1, 2'd1, 2'd3, 2'd1, 1'b1); step();
        check("g_stall1", 32'(stall_mask), 32'b0011);
        check("g_no_release", 32'(release_valid), 32'h0);
        idle();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("g_req_hold%0d", c), 32'(gbar_req_valid), 32'h1);
            check($sformatf("g_req_id%0d", c), 32'(gbar_req_id), 32'd3);
            step();
        end
        gbar_req_ready = 1'b1;
        check("g_req_before_ready", 32'(gbar_req_valid), 32'h1);
        step();
        gbar_req_ready = 1'b0;
        check("g_req_dropped", 32'(gbar_req_valid), 32'h0);
        check("g_wait_stall", 32'(stall_mask), 32'b0011);
        gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd3; step();
        gbar_rsp_valid = 1'b0;
        check("g_rel_valid", 32'(release_valid), 32'h1);
        check("g_rel_mask", 32'(release_wmask), 32'b0011);
        check("g_rel_stall", 32'(stall_mask), 32'h0);
        step();
        check("g_rel_pulse", 32'(release_valid), 32'h0);

        // Global release colliding with a local final arrival on barrier 0.
        drive(1'b1, 2'd0, 2'd3, 2'd1, 1'b1); step();
        drive(1'b1, 2'd1, 2'd3, 2'd1, 1'b1); step();
        drive(1'b1, 2'd2, 2'd0, 2'd1, 1'b0); gbar_req_ready = 1'b1; step();
        gbar_req_ready = 1'b0;
        check("c_stall", 32'(stall_mask), 32'b0111);
        drive(1'b1, 2'd3, 2'd0, 2'd1, 1'b0); gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd3; step();
        idle(); gbar_rsp_valid = 1'b0;
        check("c_rel1_valid", 32'(release_valid), 32'h1);
        check("c_rel1_mask", 32'(release_wmask), 32'b0011);
        check("c_stall_after", 32'(stall_mask), 32'h0);
        step();
        check("c_rel2_valid", 32'(release_valid), 32'h1);
        check("c_rel2_mask", 32'(release_wmask), 32'b1100);
        step();
        check("c_rel_done", 32'(release_valid), 32'h0);
`endif

        // Reset with warps waiting drops them without a release pulse.
        drive(1'b1, 2'd0, 2'd0, 2'd3, 1'b0); step();
        drive(1'b1, 2'd1, 2'd0, 2'd3, 1'b0); step();
        check("r_stall_pre", 32'(stall_mask), 32'b0011);
        idle(); reset = 1'b0; step();
        check("r_stall", 32'(stall_mask), 32'h0);
        check("r_rel_valid", 32'(release_valid), 32'h0);
        check("r_greq", 32'(gbar_req_valid), 32'h0);
        reset = 1'b1; step();
        check("r_rel_after", 32'(release_valid), 32'h0);
        drive(1'b1, 2'd2, 2'd0, 2'd1, 1'b0); step();
        check("r_cnt_cleared", 32'(stall_mask), 32'b0100);
        drive(1'b1, 2'd3, 2'd0, 2'd1, 1'b0); step();
        idle();
        check("r_new_rel_valid", 32'(release_valid), 32'h1);
        check("r_new_rel_mask", 32'(release_wmask), 32'b1100);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
